// File: rtl/stream_demux_pkg.sv
// Shared types, defaults and helpers for the registered 1-to-NCH stream demux.
package stream_demux_pkg;

  localparam int unsigned DEFAULT_DW  = 8;
  localparam int unsigned DEFAULT_NCH = 4;

  // Routing state: idle between packets, locked onto a channel, or discarding
  // a packet whose target channel does not exist.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  // True when channel index ch names a real output channel.
  function automatic logic ch_in_range(input int unsigned ch, input int unsigned nch);
    return (ch < nch);
  endfunction

endpackage

// File: rtl/stream_demux_n_slot.sv
// One-beat holding register (valid/data/last) for a single output channel.
// A write while the consumer drains the slot keeps it full, which allows
// one beat per cycle through the slot.
module demux_slot #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_wr_last,
  input  logic          i_rd,
  output logic          o_full,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  logic          r_full;
  logic [DW-1:0] r_data;
  logic          r_last;

  // Fill on write (takes priority over a same-cycle drain), empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_full <= 1'b1;
        r_data <= i_wr_data;
        r_last <= i_wr_last;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_last = r_last;

endmodule

// File: rtl/stream_demux_n.sv
// Registered, packet-locked 1-to-NCH stream demultiplexer. The first beat of
// a packet picks the target (explicit in_sel or round-robin pointer); the
// target is held until the beat flagged in_last. Packets aimed at a channel
// that does not exist are swallowed and flagged in err_sel.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW  = DEFAULT_DW,
  parameter int unsigned NCH = DEFAULT_NCH,
  parameter int unsigned SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  input  logic [SW-1:0]     in_sel,
  input  logic              rr_mode,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_last,
  output logic [SW-1:0]     cur_sel,
  output logic              err_sel
);

  // Parameter sanity: the select must be exactly wide enough for NCH.
  if (SW != $clog2(NCH)) begin : g_bad_sw
    $error("stream_demux_n: SW must equal clog2(NCH)");
  end
  if ((NCH < 2) || (NCH > 16)) begin : g_bad_nch
    $error("stream_demux_n: NCH must be in 2..16");
  end

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_tgt;
  logic [SW-1:0] r_rr_ptr;
  logic          r_rr_pkt;
  logic          r_err;

  logic [SW-1:0]  w_first_tgt;
  logic [SW-1:0]  w_tgt;
  logic           w_tgt_ok;
  logic           w_tgt_free;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_wr_any;
  logic           w_rr_adv;
  logic           w_err_set;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_wr_en;

  // The target is decided combinationally from the inputs while idle and
  // comes from the lock register once a packet is in flight.
  assign w_first_tgt = rr_mode ? r_rr_ptr : in_sel;
  assign w_tgt       = (r_state == IDLE) ? w_first_tgt : r_tgt;
  assign w_tgt_ok    = ch_in_range(32'(w_tgt), NCH);
  assign w_accept    = in_valid && w_in_ready;

  // Target slot can take a beat when empty or being drained this cycle.
  always_comb begin
    w_tgt_free = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_tgt == SW'(k)) begin
        w_tgt_free = !w_full[k] || out_ready[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: single-beat packets never leave IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !in_last) begin
          w_state_next = w_tgt_ok ? PKT : DROP;
        end
      end
      PKT, DROP: begin
        if (w_accept && in_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake, slot write strobe, pointer advance, error set.
  // in_ready is held low while reset is asserted and never looks at in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    w_wr_any   = 1'b0;
    w_rr_adv   = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = !w_tgt_ok || w_tgt_free;
        w_wr_any   = w_accept && w_tgt_ok;
        w_err_set  = w_accept && !w_tgt_ok;
        w_rr_adv   = w_accept && in_last && rr_mode;
      end
      PKT: begin
        w_in_ready = w_tgt_free;
        w_wr_any   = w_accept;
        w_rr_adv   = w_accept && in_last && r_rr_pkt;
      end
      DROP: begin
        w_in_ready = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
    w_in_ready = w_in_ready && rst_n;
  end

  // Packet lock, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt    <= '0;
      r_rr_ptr <= '0;
      r_rr_pkt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_accept) begin
        r_tgt    <= w_first_tgt;
        r_rr_pkt <= rr_mode;
      end
      if (w_rr_adv) begin
        r_rr_ptr <= (r_rr_ptr == SW'(NCH - 1)) ? '0 : r_rr_ptr + 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // One holding slot per output channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_wr_en[gi] = w_wr_any && (w_tgt == SW'(gi));

    demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_en  (w_wr_en[gi]),
      .i_wr_data(in_data),
      .i_wr_last(in_last),
      .i_rd     (out_ready[gi]),
      .o_full   (w_full[gi]),
      .o_data   (out_data[gi*DW +: DW]),
      .o_last   (out_last[gi])
    );
  end

  assign out_valid = w_full;
  assign in_ready  = w_in_ready;
  assign cur_sel   = (r_state == IDLE) ? r_rr_ptr : r_tgt;
  assign err_sel   = r_err;

endmodule
